// File: rtl/custom_axi_regif.sv
// APB3 slave register front end for custom_axi_ip: turns CPU writes into held per-channel strobes,
// shadows IP read data with sticky valid flags, and reports ack timeouts as PSLVERR.
module custom_axi_regif #(
    parameter int ADDR_W      = 12,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [2:0]        reg2ip_data_o,
    output logic [2:0]        reg2ip_en_o,
    input  logic [2:0]        reg2ip_ack_i,
    input  logic [2:0]        ip2reg_data_i,
    input  logic [2:0]        ip2reg_en_i
);

    localparam int         WORD_W   = ADDR_W - 2;
    localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RESP
    } state_t;

    state_t      state;
    logic [1:0]  ch;
    logic        wbit;
    logic [7:0]  cnt;
    logic [2:0]  wr_shadow;
    logic [2:0]  rd_shadow;
    logic [2:0]  valid;
    logic [2:0]  timeout;

    logic [WORD_W-1:0] word;
    logic [2:0]        idx;
    logic              in_window;
    logic              access;

    assign word      = paddr_i[ADDR_W-1:2];
    assign idx       = word[2:0];
    assign in_window = (word[WORD_W-1:3] == '0);
    assign access    = psel_i & penable_i & (state == IDLE);

    logic        wr_hit;
    logic        rd_hit;
    logic        stat_hit;
    logic        bad;
    logic [1:0]  sel;
    logic [31:0] rvalue;
    logic [2:0]  rd_clear;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        wr_hit   = 1'b0;
        rd_hit   = 1'b0;
        stat_hit = 1'b0;
        sel      = 2'd0;
        rvalue   = '0;
        if (in_window) begin
            case (idx)
                3'd0: begin wr_hit = 1'b1; sel = 2'd0; rvalue = {31'b0, wr_shadow[0]}; end
                3'd1: begin wr_hit = 1'b1; sel = 2'd1; rvalue = {31'b0, wr_shadow[1]}; end
                3'd2: begin wr_hit = 1'b1; sel = 2'd2; rvalue = {31'b0, wr_shadow[2]}; end
                3'd3: begin rd_hit = 1'b1; sel = 2'd0; rvalue = {31'b0, rd_shadow[0]}; end
                3'd4: begin rd_hit = 1'b1; sel = 2'd1; rvalue = {31'b0, rd_shadow[1]}; end
                3'd5: begin rd_hit = 1'b1; sel = 2'd2; rvalue = {31'b0, rd_shadow[2]}; end
                3'd6: begin stat_hit = 1'b1; rvalue = {26'b0, timeout, valid}; end
                default: ;
            endcase
        end
        bad      = !(wr_hit || rd_hit || stat_hit) || (pwrite_i && rd_hit);
        rd_clear = (access && !pwrite_i && rd_hit) ? (3'b001 << sel) : 3'b000;
    end

    // Capture has priority over the read-clear so a value arriving during the read is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_shadow <= '0;
            valid     <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ip2reg_en_i[k]) begin
                    rd_shadow[k] <= ip2reg_data_i[k];
                    valid[k]     <= 1'b1;
                end else if (rd_clear[k]) begin
                    valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ch            <= 2'd0;
            wbit          <= 1'b0;
            cnt           <= 8'd0;
            wr_shadow     <= '0;
            timeout       <= '0;
            prdata_o      <= '0;
            pready_o      <= 1'b0;
            pslverr_o     <= 1'b0;
            reg2ip_data_o <= '0;
            reg2ip_en_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (pwrite_i && wr_hit) begin
                            ch                 <= sel;
                            wbit               <= pwdata_i[0];
                            reg2ip_data_o[sel] <= pwdata_i[0];
                            reg2ip_en_o        <= 3'b001 << sel;
                            cnt                <= 8'd0;
                            state              <= WAIT_ACK;
                        end else begin
                            pready_o  <= 1'b1;
                            pslverr_o <= bad;
                            prdata_o  <= (pwrite_i || bad) ? 32'd0 : rvalue;
                            if (pwrite_i && stat_hit) begin
                                timeout <= timeout & ~pwdata_i[5:3];
                            end
                            state     <= RESP;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (reg2ip_ack_i[ch]) begin
                        reg2ip_en_o   <= '0;
                        pready_o      <= 1'b1;
                        pslverr_o     <= 1'b0;
                        wr_shadow[ch] <= wbit;
                        state         <= RESP;
                    end else if (cnt == LAST_CNT) begin
                        reg2ip_en_o <= '0;
                        pready_o    <= 1'b1;
                        pslverr_o   <= 1'b1;
                        timeout[ch] <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    prdata_o  <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pwdata_i[31:6], pwdata_i[2:1], paddr_i[1:0]};

endmodule

// File: tb/tb_custom_axi_regif.sv
// Self-checking bench for custom_axi_regif: APB driver plus a response scoreboard, one task per scenario.
module tb_custom_axi_regif;

    localparam int ADDR_W      = 12;
    localparam int ACK_TIMEOUT = 16;

    localparam logic [11:0] A_WR0  = 12'h000;
    localparam logic [11:0] A_WR1  = 12'h004;
    localparam logic [11:0] A_WR2  = 12'h008;
    localparam logic [11:0] A_RD0  = 12'h00C;
    localparam logic [11:0] A_RD1  = 12'h010;
    localparam logic [11:0] A_RD2  = 12'h014;
    localparam logic [11:0] A_STAT = 12'h018;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [2:0]        reg2ip_data;
    logic [2:0]        reg2ip_en;
    logic [2:0]        reg2ip_ack;
    logic [2:0]        ip2reg_data;
    logic [2:0]        ip2reg_en;

    always #5 clk = ~clk;

    custom_axi_regif #(
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .paddr_i       (paddr),
        .psel_i        (psel),
        .penable_i     (penable),
        .pwrite_i      (pwrite),
        .pwdata_i      (pwdata),
        .prdata_o      (prdata),
        .pready_o      (pready),
        .pslverr_o     (pslverr),
        .reg2ip_data_o (reg2ip_data),
        .reg2ip_en_o   (reg2ip_en),
        .reg2ip_ack_i  (reg2ip_ack),
        .ip2reg_data_i (ip2reg_data),
        .ip2reg_en_i   (ip2reg_en)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   en_cnt[3];
    int   data_hi_cnt[3];
    int   onehot_bad = 0;

    // Response scoreboard and strobe observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (pready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_response: pready=1 prdata=%h pslverr=%b, none expected",
                         prdata, pslverr);
            end else begin
                mon_e = sb.pop_front();
                if (prdata !== mon_e.rdata || pslverr !== mon_e.err)
                    $display("FAIL %s: prdata=%h pslverr=%b, expected prdata=%h pslverr=%b",
                             mon_e.name, prdata, pslverr, mon_e.rdata, mon_e.err);
                else
                    n_pass++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (reg2ip_en[k]) en_cnt[k]++;
            if (reg2ip_en[k] && reg2ip_data[k]) data_hi_cnt[k]++;
        end
        if ($countones(reg2ip_en) > 1) onehot_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) begin
            en_cnt[k]      = 0;
            data_hi_cnt[k] = 0;
        end
    endtask

    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input string name, output int lat);
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (pready) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_checks++;
            $display("FAIL %s: pready not seen within 40 cycles", name);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic pulse_capture(input logic [2:0] en, input logic [2:0] data);
        @(posedge clk); #1;
        ip2reg_en = en; ip2reg_data = data;
        @(posedge clk); #1;
        ip2reg_en = '0; ip2reg_data = '0;
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (reg2ip_en !== 3'b000 || pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'd0)
            $display("FAIL reset_outputs: en=%b pready=%b pslverr=%b prdata=%h, expected all 0",
                     reg2ip_en, pready, pslverr, prdata);
        else
            n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_after_reset", lat);
        n_checks++;
        if (lat !== 1) $display("FAIL read_latency: got %0d cycles, expected 1", lat);
        else n_pass++;
    endtask

    task automatic test_write_ack();
        int lat;
        clear_counts();
        fork
            apb_xfer(A_WR1, 1'b1, 32'd1, 32'd0, 1'b0, "wr1_ack", lat);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (reg2ip_en[1]) break;
                end
                @(posedge clk);
                @(posedge clk); #1;
                reg2ip_ack = 3'b010;
            end
        join
        reg2ip_ack = 3'b000;
        n_checks++;
        if (en_cnt[1] !== 3) $display("FAIL wr1_strobe_len: got %0d cycles, expected 3", en_cnt[1]);
        else n_pass++;
        n_checks++;
        if (data_hi_cnt[1] !== 3) $display("FAIL wr1_strobe_data: got %0d cycles, expected 3", data_hi_cnt[1]);
        else n_pass++;
        n_checks++;
        if (lat !== 4) $display("FAIL wr1_latency: got %0d cycles, expected 4", lat);
        else n_pass++;
        apb_xfer(A_WR1, 1'b0, 32'd0, 32'd1, 1'b0, "wr1_readback", lat);
        apb_xfer(A_WR0, 1'b0, 32'd0, 32'd0, 1'b0, "wr0_untouched", lat);
    endtask

    task automatic test_timeout();
        int lat;
        clear_counts();
        apb_xfer(A_WR2, 1'b1, 32'd1, 32'd0, 1'b1, "wr2_timeout", lat);
        n_checks++;
        if (lat !== ACK_TIMEOUT + 1)
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", lat, ACK_TIMEOUT + 1);
        else
            n_pass++;
        n_checks++;
        if (en_cnt[2] !== ACK_TIMEOUT)
            $display("FAIL wr2_strobe_len: got %0d cycles, expected %0d", en_cnt[2], ACK_TIMEOUT);
        else
            n_pass++;
        apb_xfer(A_WR2, 1'b0, 32'd0, 32'd0, 1'b0, "wr2_not_updated", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h20, 1'b0, "status_timeout2", lat);
        apb_xfer(A_STAT, 1'b1, 32'h20, 32'd0, 1'b0, "status_w1c", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_cleared", lat);
    endtask

    task automatic test_capture();
        int lat;
        pulse_capture(3'b001, 3'b001);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h1, 1'b0, "status_valid0", lat);
        apb_xfer(A_RD0, 1'b0, 32'd0, 32'd1, 1'b0, "rd0_value", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_valid0_cleared", lat);
        pulse_capture(3'b001, 3'b001);
        fork
            apb_xfer(A_RD0, 1'b0, 32'd0, 32'd1, 1'b0, "rd0_collide_old", lat);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (psel && penable) break;
                end
                ip2reg_en = 3'b001; ip2reg_data = 3'b000;
                @(posedge clk); #1;
                ip2reg_en = '0;
            end
        join
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h1, 1'b0, "status_capture_wins", lat);
        apb_xfer(A_RD0, 1'b0, 32'd0, 32'd0, 1'b0, "rd0_new_value", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_after_rd0", lat);
        pulse_capture(3'b110, 3'b110);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h6, 1'b0, "status_valid12", lat);
        apb_xfer(A_RD2, 1'b0, 32'd0, 32'd1, 1'b0, "rd2_value", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h2, 1'b0, "status_valid1_only", lat);
    endtask

    task automatic test_errors();
        int lat;
        clear_counts();
        apb_xfer(12'h01C, 1'b0, 32'd0, 32'd0, 1'b1, "read_unmapped", lat);
        n_checks++;
        if (lat !== 1) $display("FAIL error_latency: got %0d cycles, expected 1", lat);
        else n_pass++;
        apb_xfer(12'h01C, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, "write_unmapped", lat);
        apb_xfer(A_RD1, 1'b1, 32'd0, 32'd0, 1'b1, "write_rd1", lat);
        apb_xfer(12'h040, 1'b0, 32'd0, 32'd0, 1'b1, "read_beyond_map", lat);
        n_checks++;
        if (en_cnt[0] + en_cnt[1] + en_cnt[2] !== 0)
            $display("FAIL error_no_strobe: got %0d strobe cycles, expected 0",
                     en_cnt[0] + en_cnt[1] + en_cnt[2]);
        else
            n_pass++;
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h2, 1'b0, "status_after_errors", lat);
        apb_xfer(A_RD1, 1'b0, 32'd0, 32'd1, 1'b0, "rd1_after_errors", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_after_rd1", lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        reg2ip_ack = 3'b010;
        apb_xfer(A_WR0, 1'b1, 32'd1, 32'd0, 1'b1, "wr0_wrong_ack", lat);
        n_checks++;
        if (lat !== ACK_TIMEOUT + 1)
            $display("FAIL wrong_ack_latency: got %0d cycles, expected %0d", lat, ACK_TIMEOUT + 1);
        else
            n_pass++;
        apb_xfer(A_WR0, 1'b0, 32'd0, 32'd0, 1'b0, "wr0_after_timeout", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'h08, 1'b0, "status_timeout0", lat);
        reg2ip_ack = 3'b001;
        apb_xfer(A_WR0, 1'b1, 32'd1, 32'd0, 1'b0, "wr0_min_latency", lat);
        n_checks++;
        if (lat !== 2) $display("FAIL min_write_latency: got %0d cycles, expected 2", lat);
        else n_pass++;
        reg2ip_ack = 3'b000;
        apb_xfer(A_WR0, 1'b0, 32'd0, 32'd1, 1'b0, "wr0_readback", lat);
        apb_xfer(A_WR1, 1'b0, 32'd0, 32'd1, 1'b0, "wr1_still_set", lat);
        apb_xfer(A_STAT, 1'b1, 32'h08, 32'd0, 1'b0, "status_w1c_bit3", lat);
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_clear_again", lat);
        n_checks++;
        if (onehot_bad !== 0) $display("FAIL strobe_onehot: got %0d bad cycles, expected 0", onehot_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int ready_seen;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = A_WR1; pwrite = 1'b1; pwdata = 32'd1;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (reg2ip_en[1]) break;
        end
        n_checks++;
        if (reg2ip_en !== 3'b010) $display("FAIL mid_strobe_up: en=%b, expected 010", reg2ip_en);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (reg2ip_en !== 3'b000) $display("FAIL mid_strobe_drop: en=%b, expected 000", reg2ip_en);
        else n_pass++;
        ready_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (pready) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) $display("FAIL mid_no_response: pready cycles=%0d, expected 0", ready_seen);
        else n_pass++;
        apb_xfer(A_WR1, 1'b0, 32'd0, 32'd0, 1'b0, "wr1_after_reset", lat);
        n_checks++;
        if (lat !== 1) $display("FAIL idle_after_reset: got %0d cycles, expected 1", lat);
        else n_pass++;
        apb_xfer(A_STAT, 1'b0, 32'd0, 32'd0, 1'b0, "status_after_mid_reset", lat);
    endtask

    initial begin
        rst = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        reg2ip_ack = '0; ip2reg_data = '0; ip2reg_en = '0;
        clear_counts();
        test_reset();
        test_write_ack();
        test_timeout();
        test_capture();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
